// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and hold/flush controls between the pipeline datapath and pipe_stall_ctrl.
// Combinational path only; the controller is the slave side.
interface pipe_stall_ctrl_if #(
    parameter int REGW = 5
);
    logic [1:0]      idex_memr;
    logic [REGW-1:0] idex_rd;
    logic [REGW-1:0] ifid_rs1;
    logic [REGW-1:0] ifid_rs2;
    logic            br_taken;
    logic            dmem_wait;
    logic            pc_hold;
    logic            pc_redirect;
    logic            ifid_hold;
    logic            ifid_flush;
    logic            idex_flush;
    logic            exmem_hold;
    logic [1:0]      ctrl_state;

    modport master (
        output idex_memr, idex_rd, ifid_rs1, ifid_rs2, br_taken, dmem_wait,
        input  pc_hold, pc_redirect, ifid_hold, ifid_flush, idex_flush, exmem_hold, ctrl_state
    );

    modport slave (
        input  idex_memr, idex_rd, ifid_rs1, ifid_rs2, br_taken, dmem_wait,
        output pc_hold, pc_redirect, ifid_hold, ifid_flush, idex_flush, exmem_hold, ctrl_state
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer, priority dmem_wait > branch > load-use; controls are same-cycle (Mealy),
// dmem_wait back-pressures by holding PC..EX/MEM. PIPE_STATS_EN adds saturating event counters.
module pipe_stall_ctrl #(
    parameter int REGW         = 5,
    parameter int FLUSH_CYCLES = 1
`ifdef PIPE_STATS_EN
    ,
    parameter int CNTW         = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_stall_ctrl_if.slave  bus
`ifdef PIPE_STATS_EN
    ,
    output logic [CNTW-1:0]   stall_cnt,
    output logic [CNTW-1:0]   flush_cnt,
    output logic [CNTW-1:0]   wait_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        MWAIT = 2'd3
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         FLUSH_EN = (FLUSH_CYCLES > 1);

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      cnt;
    logic [2:0]      cnt_nxt;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic            lu;
    logic            do_hold;
    logic            do_redir;
    logic            do_bubble;
    logic            do_flush;

    assign rd  = bus.idex_rd;
    assign rs1 = bus.ifid_rs1;
    assign rs2 = bus.ifid_rs2;
    assign lu  = (|bus.idex_memr) & (rd != '0) & ((rd == rs1) | (rd == rs2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // RUN and a released MWAIT decode identically; MWAIT with dmem_wait high just re-holds.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_hold   = 1'b0;
        do_redir  = 1'b0;
        do_bubble = 1'b0;
        do_flush  = 1'b0;
        if (bus.dmem_wait) begin
            do_hold   = 1'b1;
            state_nxt = MWAIT;
        end else if (bus.br_taken) begin
            do_redir = 1'b1;
            if (FLUSH_EN) begin
                state_nxt = FLUSH;
                cnt_nxt   = CNT_LOAD;
            end else begin
                state_nxt = RUN;
            end
        end else begin
            case (state)
                FLUSH: begin
                    do_flush = 1'b1;
                    if (cnt <= 3'd1) state_nxt = RUN;
                    else             cnt_nxt   = cnt - 3'd1;
                end
                STALL: state_nxt = RUN;  // stale ID/EX match must not bubble twice
                default: begin
                    if (lu) begin
                        do_bubble = 1'b1;
                        state_nxt = STALL;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            endcase
        end
    end

    assign bus.pc_hold     = rst_n & (do_hold | do_bubble);
    assign bus.pc_redirect = rst_n & do_redir;
    assign bus.ifid_hold   = rst_n & (do_hold | do_bubble);
    assign bus.ifid_flush  = rst_n & (do_redir | do_flush);
    assign bus.idex_flush  = rst_n & (do_redir | do_bubble);
    assign bus.exmem_hold  = rst_n & do_hold;
    assign bus.ctrl_state  = state;

`ifdef PIPE_STATS_EN
    localparam logic [CNTW-1:0] SAT = '1;
    localparam logic [CNTW-1:0] ONE = 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (do_bubble && stall_cnt != SAT) stall_cnt <= stall_cnt + ONE;
            if (do_redir && flush_cnt != SAT)  flush_cnt <= flush_cnt + ONE;
            if (state == MWAIT && bus.dmem_wait && wait_cnt != SAT) wait_cnt <= wait_cnt + ONE;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl (FLUSH_CYCLES = 3); stats counters checked when PIPE_STATS_EN is set.
module tb_pipe_stall_ctrl;
    localparam int REGW = 5;
    localparam int FC   = 3;
    localparam int CNTW = 4;
    localparam int SATV = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.REGW(REGW)) bus ();

`ifdef PIPE_STATS_EN
    logic [CNTW-1:0] stall_cnt, flush_cnt, wait_cnt;
    pipe_stall_ctrl #(.REGW(REGW), .FLUSH_CYCLES(FC), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );
`else
    pipe_stall_ctrl #(.REGW(REGW), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    // ctl bit order: {pc_hold, pc_redirect, ifid_hold, ifid_flush, idex_flush, exmem_hold}
    typedef struct {
        logic [5:0] ctl;
        logic [1:0] st;
        bit         known;
        int         sc;
        int         fc;
        int         wc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: pipeline situation described by what is pending, not by FSM encoding.
    bit m_known   = 0;
    bit m_waiting = 0;
    bit m_stalled = 0;
    int m_left    = 0;
    int m_sc = 0, m_fc = 0, m_wc = 0;

    function automatic logic [1:0] model_state();
        if (m_waiting)       return 2'd3;
        else if (m_left > 0) return 2'd2;
        else if (m_stalled)  return 2'd1;
        else                 return 2'd0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SATV) ? SATV : v + 1;
    endfunction

    task automatic drive(input bit r, input logic [1:0] m, input int rd, input int rs1,
                         input int rs2, input bit br, input bit dw);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst_n          = r;
        bus.idex_memr  = m;
        bus.idex_rd    = REGW'(rd);
        bus.ifid_rs1   = REGW'(rs1);
        bus.ifid_rs2   = REGW'(rs2);
        bus.br_taken   = br;
        bus.dmem_wait  = dw;
        lu = (m != 2'b00) && (rd != 0) && (rd == rs1 || rd == rs2);
        e.st    = model_state();
        e.known = m_known;
        e.sc    = m_sc;
        e.fc    = m_fc;
        e.wc    = m_wc;
        e.ctl   = 6'b000000;
        if (!r) begin
            m_known = 1; m_waiting = 0; m_stalled = 0; m_left = 0;
            m_sc = 0; m_fc = 0; m_wc = 0;
        end else if (dw) begin
            e.ctl = 6'b101001;
            if (m_waiting) m_wc = sat_inc(m_wc);
            m_waiting = 1; m_stalled = 0; m_left = 0;
        end else if (br) begin
            e.ctl = 6'b010110;
            m_fc = sat_inc(m_fc);
            m_waiting = 0; m_stalled = 0; m_left = FC - 1;
        end else if (m_left > 0) begin
            e.ctl = 6'b000100;
            m_waiting = 0; m_stalled = 0; m_left--;
        end else if (lu && !m_stalled) begin
            e.ctl = 6'b101010;
            m_sc = sat_inc(m_sc);
            m_waiting = 0; m_stalled = 1;
        end else begin
            m_waiting = 0; m_stalled = 0;
        end
        q.push_back(e);
    endtask

    exp_t       got;
    logic [5:0] act;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            got = q.pop_front();
            act = {bus.pc_hold, bus.pc_redirect, bus.ifid_hold,
                   bus.ifid_flush, bus.idex_flush, bus.exmem_hold};
            n_vec++;
            if (act !== got.ctl) begin
                n_err++;
                $display("FAIL ctl @%0t: got %b expected %b", $time, act, got.ctl);
            end
            n_vec++;
            if (((bus.pc_hold & bus.pc_redirect) | (bus.ifid_hold & bus.ifid_flush)) !== 1'b0) begin
                n_err++;
                $display("FAIL excl @%0t: hold/redirect/flush overlap in %b, expected none", $time, act);
            end
            if (got.known) begin
                n_vec++;
                if (bus.ctrl_state !== got.st) begin
                    n_err++;
                    $display("FAIL state @%0t: got %0d expected %0d", $time, bus.ctrl_state, got.st);
                end
`ifdef PIPE_STATS_EN
                n_vec++;
                if (stall_cnt !== CNTW'(got.sc) || flush_cnt !== CNTW'(got.fc) ||
                    wait_cnt !== CNTW'(got.wc)) begin
                    n_err++;
                    $display("FAIL stats @%0t: got s%0d f%0d w%0d expected s%0d f%0d w%0d", $time,
                             stall_cnt, flush_cnt, wait_cnt, got.sc, got.fc, got.wc);
                end
`endif
            end
        end
    end

    bit rdw;
    initial begin
        bus.idex_memr = 2'b00; bus.idex_rd = '0; bus.ifid_rs1 = '0; bus.ifid_rs2 = '0;
        bus.br_taken = 1'b0; bus.dmem_wait = 1'b0;
        repeat (3) drive(0, 2'b00, 0, 0, 0, 0, 0);
        // x0 destination never stalls
        repeat (2) drive(1, 2'b10, 0, 3, 0, 0, 0);
        // load-use held steady: bubble, one masked cycle, bubble again
        repeat (4) drive(1, 2'b01, 5, 5, 0, 0, 0);
        drive(1, 2'b00, 0, 0, 0, 0, 0);
        // taken branch: redirect then a 3-cycle IF/ID flush
        drive(1, 2'b00, 0, 0, 0, 1, 0);
        repeat (4) drive(1, 2'b00, 0, 0, 0, 0, 0);
        // memory wait masks branch and load-use; branch wins on release
        repeat (4) drive(1, 2'b01, 5, 5, 0, 1, 1);
        drive(1, 2'b01, 5, 5, 0, 1, 0);
        repeat (4) drive(1, 2'b00, 0, 0, 0, 0, 0);
        // reset while waiting
        repeat (3) drive(1, 2'b00, 0, 0, 0, 0, 1);
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        repeat (2) drive(1, 2'b00, 0, 0, 0, 0, 0);
        // 20 load-use bubbles (saturates a 4-bit stall counter)
        repeat (40) drive(1, 2'b01, 5, 5, 7, 0, 0);
        drive(1, 2'b00, 0, 0, 0, 0, 0);
        rdw = 0;
        for (int i = 0; i < 1500; i++) begin
            rdw = rdw ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            drive(($urandom_range(0, 63) != 0), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0), rdw);
        end
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
